avalon_lsu: RTL
===============

AVALON_LSU -- requirements
Module: avalon_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus width in bits; legal values 32 and 64; NB = DATA_W/8 byte lanes.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1, meaning 1 = MSB at lowest address, 0 = LSB at lowest address.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_op (in, 3, lsu_op_t), req_addr (in, ADDR_W), req_wdata (in, 32), meaning the CPU request channel.
REQ-007 SHALL have ports rsp_valid (out, 1), rsp_rdata (out, 32), rsp_err (out, 1), meaning the completion: load result or store acknowledge.
REQ-008 SHALL have ports avm_address (out, ADDR_W, NB-aligned), avm_read (out, 1), avm_write (out, 1), avm_writedata (out, DATA_W), avm_byteenable (out, NB), avm_readdata (in, DATA_W), avm_waitrequest (in, 1), meaning the Avalon-MM master.

Function
REQ-009 SHALL support ops LB, LBU, LH, LHU, LW, SB, SH, SW; sizes 1/2/4 bytes.
REQ-010 SHALL accept a request when req_valid and req_ready are both 1; req_ready is 1 only in IDLE.
REQ-011 SHALL implement FSM IDLE -> ACC1 -> (ACC2 when split) -> RESP -> IDLE; RESP lasts exactly one cycle with rsp_valid=1.
REQ-012 SHALL register op, address and write data at acceptance; request inputs are ignored outside IDLE.
REQ-013 SHALL hold avm_address/avm_read/avm_write/avm_writedata/avm_byteenable stable in ACCx while avm_waitrequest=1; advance only in the cycle with waitrequest=0.
REQ-014 SHALL capture avm_readdata in the read cycle where avm_waitrequest=0 (zero-latency slave).
REQ-015 SHALL place the byte at address A on lane A mod NB; byteenable set only for lanes covered by the access.
REQ-016 SHALL order multi-byte data per BIG_ENDIAN: value MSB at lowest address when 1, LSB when 0, for both loads and stores.
REQ-017 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; rsp_rdata for stores is 0.
REQ-018 SHALL give minimum latency 3 cycles accept-to-rsp_valid with no waitrequest (unsplit), plus one per waitrequest cycle.
REQ-019 SHALL, for an access crossing an NB boundary without SPLIT, perform no bus access, go IDLE -> RESP, assert rsp_err=1, rsp_rdata=0.
REQ-020 SHALL, for an access not crossing a boundary but misaligned to its size, complete normally (no error).
REQ-021 SHALL keep avm_read and avm_write mutually exclusive and never both 1.

Reset
REQ-022 SHALL on reset enter IDLE asynchronously: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, avm_read=0, avm_write=0, avm_byteenable=0, avm_address=0, avm_writedata=0.
REQ-023 SHALL abandon any in-flight access on reset mid-operation with no response issued.

Configuration
REQ-024 SHALL compile boundary-split support when LSU_UNALIGNED_SPLIT_EN is defined: a crossing access becomes two bus accesses (ACC1 lower word, ACC2 next word), merged into one response, rsp_err=0.
REQ-025 SHALL without LSU_UNALIGNED_SPLIT_EN omit ACC2 and behave per REQ-019.

Structure
REQ-026 SHALL place lsu_op_t, lsu_state_t and size-decode constants in package lsu_pkg.
REQ-027 SHALL contain one sub-module lsu_lane_align (combinational lane shift, byteenable generation, endian reorder, extension) instantiated once per access slot.

Verification
REQ-028 SHALL test LW 0x100, readdata 0x11223344, BIG_ENDIAN=1, no wait -> rsp_rdata 0x44332211 at cycle 3.
REQ-029 SHALL test LB 0x103, lane3=0x80, BIG_ENDIAN=1 -> byteenable 4'b1000, rsp_rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-030 SHALL test SH 0x202 wdata 0xABCD, BIG_ENDIAN=1, waitrequest=1 for 2 cycles -> byteenable 4'b1100, writedata[31:16]=0xCDAB held stable, rsp_valid at cycle 5.
REQ-031 SHALL test LW 0x101 without macro -> rsp_err=1, no avm_read; with macro -> two reads 0x100, 0x104 (byteenable 1110 then 0001), merged result.
REQ-032 SHALL test reset asserted during ACC1 with waitrequest=1 -> avm_read=0 immediately, no rsp_valid, next request accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and size decode for the Avalon load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC1,
    ST_ACC2,
    ST_RESP
  } lsu_state_t;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  function automatic logic [2:0] op_size(input lsu_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SIZE_B;
      OP_LH, OP_LHU, OP_SH: return SIZE_H;
      default:              return SIZE_W;
    endcase
  endfunction

  function automatic logic op_is_store(input lsu_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic op_is_signed(input lsu_op_t op);
    return op inside {OP_LB, OP_LH};
  endfunction

  // True when an access of 'size' bytes starting at lane 'off' runs past the bus word.
  function automatic logic crosses(input logic [3:0] off, input logic [2:0] size, input int nb);
    return (int'(off) + int'(size)) > nb;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane mapping for one bus word of an access: byteenables,
// store-data lane placement, load-byte gathering, endian reorder and extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int NB         = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic signed [4:0]    idx_base,   // (word base address) - (access address)
  input  logic [2:0]           size,
  input  logic                 sign_ext,
  input  logic                 extend_en,  // 0: return raw gathered bytes for a later merge
  input  logic [31:0]          wdata,
  input  logic [NB*8-1:0]      lane_rdata,
  input  logic [31:0]          part_in,
  output logic [NB-1:0]        byteenable,
  output logic [NB*8-1:0]      lane_wdata,
  output logic [31:0]          rdata
);

  int          k;
  int          sig;
  logic [31:0] merged;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    byteenable = '0;
    lane_wdata = '0;
    merged     = part_in;
    rdata      = '0;
    k          = 0;
    sig        = 0;
    for (int l = 0; l < NB; l++) begin
      k = l + int'(idx_base);
      if (k >= 0 && k < int'(size)) begin
        // k is the byte's offset from the access address; sig is its significance in the value
        sig = (BIG_ENDIAN != 0) ? int'(size) - 1 - k : k;
        byteenable[l]         = 1'b1;
        lane_wdata[l*8 +: 8]  = wdata[sig*8 +: 8];
        merged[sig*8 +: 8]    = lane_rdata[l*8 +: 8];
      end
    end
    rdata = merged;
    if (extend_en) begin
      case (size)
        SIZE_B:  rdata = {{24{sign_ext & merged[7]}}, merged[7:0]};
        SIZE_H:  rdata = {{16{sign_ext & merged[15]}}, merged[15:0]};
        default: rdata = merged;
      endcase
    end
  end

endmodule

// File: rtl/avalon_lsu.sv
// Load/store unit with an Avalon-MM master port. Define LSU_UNALIGNED_SPLIT_EN
// to split word-crossing accesses into two bus cycles instead of erroring.
module avalon_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  lsu_op_t               req_op,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] base;
  logic [2:0]        size;
  logic              is_store;
  logic              is_signed;
  logic              split;
  logic              req_err;

  logic signed [4:0] idx0;
  logic [NB-1:0]     be0;
  logic [DATA_W-1:0] wd0;
  logic [31:0]       rd0;

  assign off       = addr_q[OFF_W-1:0];
  assign base      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign size      = op_size(op_q);
  assign is_store  = op_is_store(op_q);
  assign is_signed = op_is_signed(op_q);
  assign idx0      = -$signed(5'(off));

  lsu_lane_align #(.NB(NB), .BIG_ENDIAN(BIG_ENDIAN)) u_slot0 (
    .idx_base   (idx0),
    .size       (size),
    .sign_ext   (is_signed),
    .extend_en  (!split),
    .wdata      (wdata_q),
    .lane_rdata (avm_readdata),
    .part_in    (32'h0),
    .byteenable (be0),
    .lane_wdata (wd0),
    .rdata      (rd0)
  );

`ifdef LSU_UNALIGNED_SPLIT_EN
  logic signed [4:0] idx1;
  logic [NB-1:0]     be1;
  logic [DATA_W-1:0] wd1;
  logic [31:0]       rd1;
  logic [31:0]       part_q;

  assign split   = crosses(4'(off), size, NB);
  assign req_err = 1'b0;
  assign idx1    = $signed(5'(NB)) - $signed(5'(off));

  lsu_lane_align #(.NB(NB), .BIG_ENDIAN(BIG_ENDIAN)) u_slot1 (
    .idx_base   (idx1),
    .size       (size),
    .sign_ext   (is_signed),
    .extend_en  (1'b1),
    .wdata      (wdata_q),
    .lane_rdata (avm_readdata),
    .part_in    (part_q),
    .byteenable (be1),
    .lane_wdata (wd1),
    .rdata      (rd1)
  );

  // Bytes gathered from the first word of a split load, merged in ACC2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      part_q <= '0;
    end else if (state_q == ST_ACC1 && !avm_waitrequest && split) begin
      part_q <= rd0;
    end
  end
`else
  assign split   = 1'b0;
  assign req_err = crosses(4'(req_addr[OFF_W-1:0]), op_size(req_op), NB);
`endif

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? ST_RESP : ST_ACC1;
      end
      ST_ACC1: begin
        avm_read       = !is_store;
        avm_write      = is_store;
        avm_address    = base;
        avm_writedata  = wd0;
        avm_byteenable = be0;
        if (!avm_waitrequest) state_d = split ? ST_ACC2 : ST_RESP;
      end
`ifdef LSU_UNALIGNED_SPLIT_EN
      ST_ACC2: begin
        avm_read       = !is_store;
        avm_write      = is_store;
        avm_address    = base + ADDR_W'(NB);
        avm_writedata  = wd1;
        avm_byteenable = be1;
        if (!avm_waitrequest) state_d = ST_RESP;
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and response formation; response fields read as zero outside RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_LB;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
          end
        end
        ST_ACC1: begin
          if (!avm_waitrequest && !split) rsp_rdata <= is_store ? '0 : rd0;
        end
`ifdef LSU_UNALIGNED_SPLIT_EN
        ST_ACC2: begin
          if (!avm_waitrequest) rsp_rdata <= is_store ? '0 : rd1;
        end
`endif
        ST_RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
